fir_out_checker: RTL and testbench

Self-checking receiver for the FIR filter output stream, placed in the FIR testbench next to the sink. It watches the same DIN/VIN stream and coefficient bus that drive the filter and computes the expected output with an internal golden FIR model. Expected samples are queued in a small FIFO and compared, in order, against each VOUT-qualified DOUT from the filter. It counts mismatches and reports a final pass/fail once the stimulus signals end of simulation.

---
 rtl/fir_chk_pkg.sv | 22 ++
 rtl/fir_chk_fifo.sv | 48 ++++
 rtl/fir_out_checker.sv | 165 ++++++++++++++++
 tb/tb_fir_out_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_chk_pkg.sv
// Shared types and constants for the FIR output checker.
package fir_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned      CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ceil(log2(taps)): guard bits needed to sum taps full-width products
    function automatic int unsigned guard_bits(input int unsigned taps);
        int unsigned g;
        g = 0;
        while ((64'd1 << g) < 64'(taps)) g = g + 1;
        return g;
    endfunction

endpackage

// File: rtl/fir_chk_fifo.sv
// Synchronous FIFO for expected samples; push while full is accepted only with a pop.
module fir_chk_fifo
    import fir_chk_pkg::*;
#(
    parameter int unsigned W     = 13,
    parameter int unsigned DEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout_c,
    output logic         o_full_c,
    output logic         o_empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic [W-1:0]   r_mem [DEPTH];
    logic           w_wr_en;
    logic           w_rd_en;

    // Extra pointer MSB distinguishes full from empty
    assign o_empty_c = (r_wr_ptr == r_rd_ptr);
    assign o_full_c  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_rd_en   = i_pop && !o_empty_c;
    assign w_wr_en   = i_push && (!o_full_c || w_rd_en);
    assign o_dout_c  = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_din;
    end

endmodule

// File: rtl/fir_out_checker.sv
// Golden-model checker for the FIR output stream; FIR_CHK_TOLERANCE_EN allows a +/-1 LSB match.
module fir_out_checker
    import fir_chk_pkg::*;
#(
    parameter int unsigned nb      = 13,
    parameter int unsigned order   = 10,
    parameter int unsigned tot_bit = (order + 1) * nb,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic [nb-1:0]      DIN,
    input  logic               VIN,
    input  logic [tot_bit-1:0] b,
    input  logic [nb-1:0]      DOUT,
    input  logic               VOUT,
    input  logic               END_SIM,
    output logic               MISMATCH,
    output logic [CNT_W-1:0]   ERR_CNT,
    output logic [CNT_W-1:0]   CHK_CNT,
    output logic               OVF,
    output logic               DONE,
    output logic               PASS
);

    localparam int unsigned TAPS   = order + 1;
    localparam int unsigned PROD_W = 2 * nb;
    localparam int unsigned ACC_W  = PROD_W + guard_bits(TAPS);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_active;
    logic                     w_drain;
    logic                     w_exit;
    logic [TMO_W-1:0]         r_tmo;
    logic signed [nb-1:0]     r_x [order];
    logic signed [nb-1:0]     w_tap [TAPS];
    logic signed [PROD_W-1:0] w_prod [TAPS];
    logic signed [ACC_W-1:0]  w_acc;
    logic [nb-1:0]            w_exp;
    logic [nb-1:0]            w_fifo_dout;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_orphan;
    logic                     w_eq;
    logic                     w_fail;
    logic [CNT_W-1:0]         w_err_nxt;
    logic                     w_ovf_nxt;
    logic                     w_unused;

    // Golden MAC: tap 0 is the sample arriving this cycle
    assign w_tap[0] = $signed(DIN);
    for (genvar k = 1; k < TAPS; k++) begin : g_tap
        assign w_tap[k] = r_x[k-1];
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < int'(TAPS); k++) begin
            w_prod[k] = PROD_W'($signed(b[k*nb +: nb])) * PROD_W'(w_tap[k]);
            w_acc     = w_acc + ACC_W'(w_prod[k]);
        end
    end

    // Q1.(nb-1) truncation, no rounding or saturation
    assign w_exp    = w_acc[2*nb-2 : nb-1];
    assign w_unused = ^{w_acc[ACC_W-1:2*nb-1], w_acc[nb-2:0]};

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            for (int k = 0; k < int'(order); k++) r_x[k] <= '0;
        end else if (w_push) begin
            r_x[0] <= $signed(DIN);
            for (int k = 1; k < int'(order); k++) r_x[k] <= r_x[k-1];
        end
    end

    fir_chk_fifo #(
        .W     (nb),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (CLK),
        .i_rst_n   (RST_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_din     (w_exp),
        .o_dout_c  (w_fifo_dout),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty)
    );

`ifdef FIR_CHK_TOLERANCE_EN
    logic signed [nb:0] w_diff;
    assign w_diff = (nb+1)'($signed(DOUT)) - (nb+1)'($signed(w_fifo_dout));
    assign w_eq   = (w_diff == '0) || (w_diff == (nb+1)'(1)) || (w_diff == '1);
`else
    assign w_eq = (DOUT == w_fifo_dout);
`endif

    always_ff @(posedge CLK) begin
        if (!RST_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (END_SIM)  w_state_nxt = ST_DRAIN;
                else if (VIN) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (END_SIM) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_fifo_empty || (r_tmo == TMO_W'(TIMEOUT - 1))) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_active = 1'b1;
        w_drain  = 1'b0;
        unique case (r_state)
            ST_DRAIN: w_drain  = 1'b1;
            ST_DONE:  w_active = 1'b0;
            default:  ;
        endcase
    end

    assign w_exit    = w_drain && (w_state_nxt == ST_DONE);
    assign w_push    = VIN && w_active;
    assign w_pop     = VOUT && w_active && !w_fifo_empty;
    assign w_orphan  = VOUT && w_active && w_fifo_empty;
    assign w_fail    = w_orphan || (w_pop && !w_eq);
    assign w_err_nxt = (w_fail && (ERR_CNT != CNT_MAX)) ? ERR_CNT + CNT_W'(1) : ERR_CNT;
    assign w_ovf_nxt = OVF || (w_push && w_fifo_full && !w_pop);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_tmo    <= '0;
            MISMATCH <= 1'b0;
            ERR_CNT  <= '0;
            CHK_CNT  <= '0;
            OVF      <= 1'b0;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
        end else begin
            r_tmo    <= w_drain ? r_tmo + TMO_W'(1) : '0;
            MISMATCH <= w_fail;
            ERR_CNT  <= w_err_nxt;
            OVF      <= w_ovf_nxt;
            DONE     <= (w_state_nxt == ST_DONE);
            if (w_pop && (CHK_CNT != CNT_MAX)) CHK_CNT <= CHK_CNT + CNT_W'(1);
            if (w_exit) PASS <= (w_err_nxt == '0) && !w_ovf_nxt && w_fifo_empty;
        end
    end

endmodule

// File: tb/tb_fir_out_checker.sv
// Directed bench for fir_out_checker: impulse table, error injection, orphan, overflow, full FIFO, reset.
module tb_fir_out_checker;

    localparam int unsigned NB    = 13;
    localparam int unsigned ORDER = 10;
    localparam int unsigned TOT   = (ORDER + 1) * NB;

    logic            CLK = 1'b0;
    logic            RST_n;
    logic [NB-1:0]   DIN;
    logic            VIN;
    logic [TOT-1:0]  b;
    logic [NB-1:0]   DOUT;
    logic            VOUT;
    logic            END_SIM;
    logic            MISMATCH;
    logic [15:0]     ERR_CNT;
    logic [15:0]     CHK_CNT;
    logic            OVF;
    logic            DONE;
    logic            PASS;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [NB-1:0] din;
        logic [NB-1:0] exp;
    } vec_t;

    vec_t tbl [11];

    // b_k = (k+1)<<8, x = 4095: y_k = floor((k+1)*256*4095/4096) = 256*(k+1)-1
    localparam int EXP_IMP [11] = '{255, 511, 767, 1023, 1279, 1535, 1791, 2047, 2303, 2559, 2815};

    fir_out_checker #(
        .nb      (NB),
        .order   (ORDER),
        .tot_bit (TOT),
        .DEPTH   (8),
        .TIMEOUT (64)
    ) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .DIN      (DIN),
        .VIN      (VIN),
        .b        (b),
        .DOUT     (DOUT),
        .VOUT     (VOUT),
        .END_SIM  (END_SIM),
        .MISMATCH (MISMATCH),
        .ERR_CNT  (ERR_CNT),
        .CHK_CNT  (CHK_CNT),
        .OVF      (OVF),
        .DONE     (DONE),
        .PASS     (PASS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        n_tot++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else            n_pass++;
    endtask

    task automatic step(input logic vin_i, input logic [NB-1:0] din_i,
                        input logic vout_i, input logic [NB-1:0] dout_i);
        VIN  = vin_i;
        DIN  = din_i;
        VOUT = vout_i;
        DOUT = dout_i;
        @(posedge CLK);
        #1;
        VIN  = 1'b0;
        VOUT = 1'b0;
    endtask

    task automatic do_reset();
        RST_n   = 1'b0;
        END_SIM = 1'b0;
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        RST_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!DONE && n < max_cyc) begin
            step(1'b0, '0, 1'b0, '0);
            n++;
        end
        check(name, DONE, 1);
    endtask

    task automatic set_b_impulse();
        for (int k = 0; k <= int'(ORDER); k++) b[k*NB +: NB] = NB'((k + 1) << 8);
    endtask

    // b_0 = -1.0: expected output is -DIN
    task automatic set_b_neg_ident();
        b = '0;
        b[NB-1:0] = 13'h1000;
    endtask

    task automatic run_impulse(input string name, input int err_idx, input int err_val, input int exp_err);
        logic [NB-1:0] d;
        set_b_impulse();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            d = '0;
            if (i >= 2) d = tbl[i-2].exp + ((i - 2 == err_idx) ? NB'(err_val) : NB'(0));
            step(i < 11, (i < 11) ? tbl[i].din : NB'(0), i >= 2, d);
            if (i >= 2)
                check($sformatf("%s mismatch[%0d]", name, i - 2), MISMATCH,
                      (i - 2 == err_idx && exp_err != 0) ? 1 : 0);
        end
        check({name, " err_cnt"}, ERR_CNT, exp_err);
        check({name, " chk_cnt"}, CHK_CNT, 11);
        END_SIM = 1'b1;
        wait_done({name, " done"}, 20);
        check({name, " pass"}, PASS, (exp_err == 0) ? 1 : 0);
        END_SIM = 1'b0;
    endtask

    initial begin
        int pm1_err;
        for (int i = 0; i < 11; i++) begin
            tbl[i].din = (i == 0) ? NB'(4095) : NB'(0);
            tbl[i].exp = NB'(EXP_IMP[i]);
        end
`ifdef FIR_CHK_TOLERANCE_EN
        pm1_err = 0;
`else
        pm1_err = 1;
`endif
        RST_n = 1'b0; DIN = '0; VIN = 1'b0; DOUT = '0; VOUT = 1'b0; END_SIM = 1'b0; b = '0;

        // Reset values
        do_reset();
        check("rst mismatch", MISMATCH, 0);
        check("rst err_cnt", ERR_CNT, 0);
        check("rst chk_cnt", CHK_CNT, 0);
        check("rst ovf", OVF, 0);
        check("rst done", DONE, 0);
        check("rst pass", PASS, 0);

        run_impulse("impulse", -1, 0, 0);
        run_impulse("err5", 2, 5, 1);
        run_impulse("err1", 2, 1, pm1_err);

        // Orphan: VOUT with nothing queued
        do_reset();
        step(1'b0, '0, 1'b1, '0);
        check("orphan mismatch", MISMATCH, 1);
        check("orphan err_cnt", ERR_CNT, 1);
        check("orphan chk_cnt", CHK_CNT, 0);
        step(1'b0, '0, 1'b0, '0);
        check("orphan pulse end", MISMATCH, 0);

        // END_SIM straight from IDLE with an empty FIFO
        do_reset();
        END_SIM = 1'b1;
        wait_done("idle end done", 10);
        check("idle end pass", PASS, 1);
        END_SIM = 1'b0;

        // Overflow: 9 pushes into depth 8, then drain timeout
        set_b_neg_ident();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, NB'(i + 1), 1'b0, '0);
            if (i == 7) check("ovf after 8", OVF, 0);
        end
        check("ovf after 9", OVF, 1);
        END_SIM = 1'b1;
        for (int i = 0; i < 60; i++) step(1'b0, '0, 1'b0, '0);
        check("drain early done", DONE, 0);
        wait_done("timeout done", 10);
        check("timeout pass", PASS, 0);
        END_SIM = 1'b0;

        // Full FIFO with simultaneous push and pop holds occupancy at 8
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, NB'(i), 1'b0, '0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, NB'(i + 8), 1'b1, NB'(-i));
            check($sformatf("full pp mismatch[%0d]", i), MISMATCH, 0);
        end
        check("full pp ovf", OVF, 0);
        for (int i = 5; i <= 12; i++) begin
            step(1'b0, '0, 1'b1, NB'(-i));
            check($sformatf("full drain mismatch[%0d]", i), MISMATCH, 0);
        end
        step(1'b0, '0, 1'b1, '0);
        check("full extra orphan", MISMATCH, 1);
        check("full chk_cnt", CHK_CNT, 12);
        check("full err_cnt", ERR_CNT, 1);
        check("full ovf final", OVF, 0);

        // Reset in RUN with 4 entries queued
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, NB'(i), 1'b0, '0);
        step(1'b0, '0, 1'b1, NB'(-1));
        check("pre rst chk_cnt", CHK_CNT, 1);
        RST_n = 1'b0;
        step(1'b0, '0, 1'b0, '0);
        RST_n = 1'b1;
        check("mid rst chk_cnt", CHK_CNT, 0);
        check("mid rst err_cnt", ERR_CNT, 0);
        check("mid rst done", DONE, 0);
        step(1'b0, '0, 1'b1, NB'(-2));
        check("post rst orphan", MISMATCH, 1);
        check("post rst err_cnt", ERR_CNT, 1);
        check("post rst chk_cnt", CHK_CNT, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
